prbs_checker: RTL and testbench

- Receive-side counterpart of the team's Fibonacci LFSR pattern generator.
- Takes the serial pseudo-random bit stream that the generator produces and self-synchronises to it from the incoming bits.
- Declares lock once the stream is predictable, then counts bit errors against a free-running local reference.
- Sits at the far end of a serial link or loopback path as a built-in self-test monitor.

---
 rtl/prbs_checker.sv | 144 ++++++++++++++
 tb/tb_prbs_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the received stream, locks after a run
// of correct predictions, then counts bit errors against a free-running reference.
module prbs_checker #(
    parameter int unsigned      WIDTH    = 7,
    parameter logic [WIDTH-1:0] TAPS     = 7'b1100000,
    parameter int unsigned      LOCK_CNT = 16,
    parameter int unsigned      LOSS_CNT = 8,
    parameter int unsigned      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned SEED_W = $clog2(WIDTH + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        SEED,
        SYNC,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [SEED_W-1:0]  seed_cnt_q, seed_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic pred;
    logic mismatch;

    assign pred     = ^(sr_q & TAPS);
    assign mismatch = din ^ pred;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        seed_cnt_d  = seed_cnt_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;

        if (en) begin
            unique case (state_q)
                SEED: begin
                    sr_d = {sr_q[WIDTH-2:0], din};
                    if (seed_cnt_q == SEED_W'(WIDTH - 1)) begin
                        state_d    = SYNC;
                        seed_cnt_d = '0;
                        good_cnt_d = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end

                SYNC: begin
                    sr_d = {sr_q[WIDTH-2:0], din};
                    // An all-zero register predicts zeros forever, so it never counts as good.
                    if (!mismatch && (sr_q != '0)) begin
                        if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d    = LOCKED;
                            locked_d   = 1'b1;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else begin
                        state_d    = SEED;
                        good_cnt_d = '0;
                        seed_cnt_d = '0;
                    end
                end

                LOCKED: begin
                    sr_d = {sr_q[WIDTH-2:0], pred};
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        if (bad_cnt_q == BAD_W'(LOSS_CNT - 1)) begin
                            state_d    = SEED;
                            locked_d   = 1'b0;
                            bad_cnt_d  = '0;
                            seed_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BAD_W'(1);
                        end
                    end else begin
                        bad_cnt_d = '0;
                    end
                end

                default: begin
                    state_d = SEED;
                end
            endcase
        end

        if (clear_cnt) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            sr_q        <= '0;
            seed_cnt_q  <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            seed_cnt_q  <= seed_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: a recurrence-based reference model checked every
// cycle, plus literal expectations for lock latency, error counts and saturation.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        din = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked, err;
    logic [15:0] err_count;
    logic        locked_s, err_s;
    logic [3:0]  err_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prbs_checker #(.WIDTH(7), .TAPS(7'b1100000), .LOCK_CNT(16), .LOSS_CNT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .clear_cnt(clear_cnt),
        .locked(locked), .err(err), .err_count(err_count)
    );

    prbs_checker #(.WIDTH(7), .TAPS(7'b1100000), .LOCK_CNT(16), .LOSS_CNT(8), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .din(din), .clear_cnt(clear_cnt),
        .locked(locked_s), .err(err_s), .err_count(err_count_s)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of the last 7 reference bits, oldest first, so the
    // prediction is b[n-7] ^ b[n-6] read straight off the front of the queue.
    typedef enum {M_SEED, M_SYNC, M_LOCK} mphase_t;
    mphase_t m_phase = M_SEED;
    logic    m_hist[$];
    int      m_run = 0;
    int      m_raw = 0;
    logic    exp_err = 1'b0;
    logic    exp_locked = 1'b0;

    always @(posedge clk) begin
        logic p;
        int   ones;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
            m_phase    = M_SEED;
            m_run      = 0;
            m_raw      = 0;
            exp_err    = 1'b0;
            exp_locked = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (en) begin
                p    = m_hist[0] ^ m_hist[1];
                ones = 0;
                foreach (m_hist[i]) ones += int'(m_hist[i]);
                case (m_phase)
                    M_SEED: begin
                        m_hist.push_back(din);
                        m_run++;
                        if (m_run == 7) begin
                            m_phase = M_SYNC;
                            m_run   = 0;
                        end
                    end
                    M_SYNC: begin
                        m_hist.push_back(din);
                        if (din == p && ones != 0) begin
                            m_run++;
                            if (m_run == 16) begin
                                m_phase = M_LOCK;
                                m_run   = 0;
                            end
                        end else begin
                            m_phase = M_SEED;
                            m_run   = 0;
                        end
                    end
                    default: begin
                        m_hist.push_back(p);
                        if (din != p) begin
                            exp_err = 1'b1;
                            m_raw++;
                            m_run++;
                            if (m_run == 8) begin
                                m_phase = M_SEED;
                                m_run   = 0;
                            end
                        end else begin
                            m_run = 0;
                        end
                    end
                endcase
                void'(m_hist.pop_front());
            end
            if (clear_cnt) m_raw = 0;
            exp_locked = (m_phase == M_LOCK);
        end
    end

    always @(negedge clk) begin
        check("locked", int'(locked), int'(exp_locked));
        check("err", int'(err), int'(exp_err));
        check("err_count", int'(err_count), (m_raw > 65535) ? 65535 : m_raw);
        check("locked_w4", int'(locked_s), int'(exp_locked));
        check("err_w4", int'(err_s), int'(exp_err));
        check("err_count_w4", int'(err_count_s), (m_raw > 15) ? 15 : m_raw);
    end

    logic [6:0] g = 7'b1111111;
    bit         gaps = 1'b0;

    task automatic gen_bit(output logic b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    task automatic tick(input logic e, input logic d, input logic c);
        en        = e;
        din       = d;
        clear_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic flip, input logic clr);
        logic b;
        if (gaps) begin
            for (int k = 0; k < 4 && $urandom_range(0, 2) == 0; k++)
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        gen_bit(b);
        tick(1'b1, b ^ flip, clr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Enabled-bit index at which lock first appears, 0 if not within the bound.
    task automatic wait_lock(input int flip_at, output int at);
        at = 0;
        for (int i = 1; i <= 60 && at == 0; i++) begin
            send(1'(i == flip_at), 1'b0);
            if (locked) at = i;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int at;
        int pulses;
        bit seen;

        do_reset();
        check("reset_locked", int'(locked), 0);
        check("reset_err_count", int'(err_count), 0);

        wait_lock(0, at);
        check("clean_lock_latency", at, 23);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send(1'b0, 1'b0);
            if (err) seen = 1'b1;
        end
        check("clean_no_err", int'(seen), 0);
        check("clean_err_count", int'(err_count), 0);

        send(1'b1, 1'b0);
        check("single_err_pulse", int'(err), 1);
        check("single_err_count", int'(err_count), 1);
        send(1'b0, 1'b0);
        check("single_err_one_pulse", int'(err), 0);
        check("single_err_locked", int'(locked), 1);
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
            send(1'b1, 1'b0);
        end
        check("isolated_err_count", int'(err_count), 4);

        send(1'b0, 1'b1);
        check("clear_count", int'(err_count), 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 1'b0);
            pulses += int'(err);
        end
        check("loss_pulses", pulses, 8);
        check("loss_locked", int'(locked), 0);
        check("loss_err_count", int'(err_count), 8);
        wait_lock(0, at);
        check("relock_latency", at, 23);
        check("relock_err_count", int'(err_count), 8);

        send(1'b1, 1'b1);
        check("clear_with_err_pulse", int'(err), 1);
        check("clear_with_err_count", int'(err_count), 0);

        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        do_reset();
        check("midlock_reset_locked", int'(locked), 0);
        check("midlock_reset_count", int'(err_count), 0);
        wait_lock(0, at);
        check("reset_relock_latency", at, 23);

        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (locked) seen = 1'b1;
        end
        check("zero_stream_never_locks", int'(seen), 0);

        do_reset();
        wait_lock(12, at);
        check("sync_error_lock_latency", at, 35);
        check("sync_error_no_count", int'(err_count), 0);

        do_reset();
        gaps = 1'b1;
        wait_lock(0, at);
        check("gapped_lock_latency", at, 23);

        for (int j = 0; j < 20; j++) begin
            send(1'b1, 1'b0);
            for (int i = 0; i < int'($urandom_range(3, 6)); i++) send(1'b0, 1'b0);
        end
        check("saturate_w4", int'(err_count_s), 15);
        check("no_saturate_w16", int'(err_count), 20);
        check("saturate_locked", int'(locked), 1);

        for (int i = 0; i < 400; i++)
            send(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
        for (int i = 0; i < 20; i++)
            send(1'b1, 1'b0);
        for (int i = 0; i < 100; i++)
            send(1'($urandom_range(0, 7) == 0), 1'b0);

        gaps = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
